// File: rtl/coherence_pkg.sv
// Shared MSI coherence definitions for the requester and snoop-side controllers.
// Contents:
//   status_t   - per-line MSI status encodings (I=00, M=01, S=10)
//   bus_cmd_t  - snooping bus commands
//   rq_state_t - requester FSM states
//   rq_waiting - true for states that wait on an external event and can time out
package coherence_pkg;

    typedef enum logic [1:0] {
        I = 2'b00,
        M = 2'b01,
        S = 2'b10
    } status_t;

    typedef enum logic [1:0] {
        NONE       = 2'b00,
        READ_MISS  = 2'b01,
        WRITE_MISS = 2'b10,
        INVALIDATE = 2'b11
    } bus_cmd_t;

    typedef enum logic [2:0] {
        StIdle,
        StBusGnt,
        StWb,
        StFill,
        StDone
    } rq_state_t;

    function automatic logic rq_waiting(input rq_state_t st);
        return (st == StBusGnt) || (st == StWb) || (st == StFill);
    endfunction

endpackage

// File: rtl/cpu_rq_controller_if.sv
// Requester-side signal bundle: CPU request, cache lookup results, arbiter/memory
// handshakes and the controller's bus/array control outputs.
// Modports:
//   master - the requester controller (drives bus_req .. err)
//   slave  - the surroundings: CPU, tag/status arrays, arbiter, memory, snoop responder
interface cpu_rq_controller_if
    import coherence_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic              tag_hit;
    status_t           status_q;
    logic [ADDR_W-1:0] victim_addr;
    logic              snoop_inv;
    logic              bus_gnt;
    logic              mem_ack;

    logic              bus_req;
    bus_cmd_t          bus_cmd;
    logic [ADDR_W-1:0] bus_addr;
    logic              wb_en;
    logic              fill_en;
    logic              status_we;
    status_t           status_n;
    logic              cpu_done;
    logic              err;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, tag_hit, status_q, victim_addr,
               snoop_inv, bus_gnt, mem_ack,
        output bus_req, bus_cmd, bus_addr, wb_en, fill_en, status_we, status_n,
               cpu_done, err
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, tag_hit, status_q, victim_addr,
               snoop_inv, bus_gnt, mem_ack,
        input  bus_req, bus_cmd, bus_addr, wb_en, fill_en, status_we, status_n,
               cpu_done, err
    );

endinterface

// File: rtl/rq_timeout_cnt.sv
// Wait-state timeout counter for the requester FSM.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - restart from zero (state entry); has priority over en
//   en         - FSM is in a waiting state this cycle
//   expire     - this is the TMO_CYC-th consecutive waiting cycle
module rq_timeout_cnt #(
    parameter int unsigned TMO_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CntW = $clog2(TMO_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // cnt_q counts completed waiting cycles, so the last allowed one sees TMO_CYC-1.
    assign expire = en && (cnt_q == CntW'(TMO_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expire) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_rq_controller.sv
// MSI requester controller: turns CPU reads/writes into READ_MISS / WRITE_MISS /
// INVALIDATE bus transactions, sequences victim write-back and fill, and strobes the
// line's next status into the status array.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   rq         - cpu_rq_controller_if.master: CPU request, lookup results, arbiter and
//                memory handshakes in; bus_req/bus_cmd/bus_addr, wb_en, fill_en,
//                status_we/status_n, cpu_done, err out (all registered, reset to 0)
module cpu_rq_controller
    import coherence_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TMO_CYC = 255
) (
    input logic                clk,
    input logic                rst_n,
    cpu_rq_controller_if.master rq
);

    rq_state_t         state_q, state_d;
    bus_cmd_t          cmd_q, cmd_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              bus_req_q, bus_req_d;
    bus_cmd_t          bus_cmd_q, bus_cmd_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              wb_en_q, wb_en_d;
    logic              fill_en_q, fill_en_d;
    logic              status_we_q, status_we_d;
    status_t           status_n_q, status_n_d;
    logic              cpu_done_q, cpu_done_d;
    logic              err_q, err_d;

    logic hit;
    logic dirty_victim;
    logic tmo_expire;

    assign hit          = rq.tag_hit && (rq.status_q != I);
    assign dirty_victim = !rq.tag_hit && (rq.status_q == M);

    rq_timeout_cnt #(
        .TMO_CYC(TMO_CYC)
    ) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_d != state_q),
        .en    (rq_waiting(state_q)),
        .expire(tmo_expire)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        we_d        = we_q;
        addr_d      = addr_q;
        status_we_d = 1'b0;
        status_n_d  = I;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // cpu_done lands the cycle after DONE; the CPU still holds cpu_req
                // then, so that cycle must not start a second transaction.
                if (rq.cpu_req && !cpu_done_q) begin
                    we_d   = rq.cpu_we;
                    addr_d = rq.cpu_addr;
                    if (!rq.cpu_we && hit) begin
                        cmd_d   = NONE;
                        state_d = StDone;
                    end else if (rq.cpu_we && hit && (rq.status_q == M)) begin
                        cmd_d   = NONE;
                        state_d = StDone;
                    end else if (rq.cpu_we && hit && (rq.status_q == S)) begin
                        cmd_d   = INVALIDATE;
                        state_d = StBusGnt;
                    end else begin
                        cmd_d   = rq.cpu_we ? WRITE_MISS : READ_MISS;
                        state_d = dirty_victim ? StWb : StBusGnt;
                    end
                end
            end
            StWb: begin
                if (rq.mem_ack) begin
                    status_we_d = 1'b1;
                    status_n_d  = I;
                    state_d     = StBusGnt;
                end else if (tmo_expire) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StBusGnt: begin
                if (rq.bus_gnt) begin
                    if (cmd_q == INVALIDATE) begin
                        status_we_d = 1'b1;
                        status_n_d  = M;
                        state_d     = StDone;
                    end else begin
                        state_d = StFill;
                    end
                end else if (tmo_expire) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (rq.snoop_inv && (cmd_q == INVALIDATE)) begin
                    // Lost the upgrade race: our S copy is gone, fetch the block instead.
                    cmd_d = WRITE_MISS;
                end
            end
            StFill: begin
                if (rq.mem_ack) begin
                    status_we_d = 1'b1;
                    status_n_d  = we_q ? M : S;
                    state_d     = StDone;
                end else if (tmo_expire) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state.
        bus_req_d  = (state_d == StBusGnt);
        bus_cmd_d  = bus_req_d ? cmd_d : NONE;
        wb_en_d    = (state_d == StWb);
        fill_en_d  = (state_d == StFill);
        cpu_done_d = (state_q == StDone);
        if (wb_en_d) begin
            bus_addr_d = rq.victim_addr;
        end else if (bus_req_d) begin
            bus_addr_d = addr_d;
        end else begin
            bus_addr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cmd_q       <= NONE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            bus_req_q   <= 1'b0;
            bus_cmd_q   <= NONE;
            bus_addr_q  <= '0;
            wb_en_q     <= 1'b0;
            fill_en_q   <= 1'b0;
            status_we_q <= 1'b0;
            status_n_q  <= I;
            cpu_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            bus_req_q   <= bus_req_d;
            bus_cmd_q   <= bus_cmd_d;
            bus_addr_q  <= bus_addr_d;
            wb_en_q     <= wb_en_d;
            fill_en_q   <= fill_en_d;
            status_we_q <= status_we_d;
            status_n_q  <= status_n_d;
            cpu_done_q  <= cpu_done_d;
            err_q       <= err_d;
        end
    end

    assign rq.bus_req   = bus_req_q;
    assign rq.bus_cmd   = bus_cmd_q;
    assign rq.bus_addr  = bus_addr_q;
    assign rq.wb_en     = wb_en_q;
    assign rq.fill_en   = fill_en_q;
    assign rq.status_we = status_we_q;
    assign rq.status_n  = status_n_q;
    assign rq.cpu_done  = cpu_done_q;
    assign rq.err       = err_q;

endmodule
